uart_tx_fifo: RTL and testbench

- Byte buffer and launcher directly upstream of uart_tx.
- Host/bus side writes bytes into a 2^(AMSB+1)-deep FIFO.
- The block pops one byte at a time into uart_tx.wdata and launches it with the toggle-style push handshake.
- It waits for uart_tx to go busy and then idle again before launching the next byte; shares clk/rstn/setn with uart_tx.

---
 rtl/uart_tx_fifo.sv | 116 +++++++++++
 tb/tb_uart_tx_fifo.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx: buffers host writes and launches one byte at a time
// using the toggle push handshake, waiting for each transmission to finish.
module uart_tx_fifo #(
    parameter int DMSB = 7,
    parameter int AMSB = 3
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            setn,
    input  logic            wr,
    input  logic [DMSB:0]   wdata,
    input  logic            clear,
    output logic            wfull,
    output logic [AMSB+1:0] level,
    output logic            overflow,
    output logic            busy,
    output logic            tx_push,
    output logic [DMSB:0]   tx_wdata,
    input  logic            tx_empty
);

    localparam int DEPTH = 2 ** (AMSB + 1);
    localparam logic [AMSB+1:0] LVL_ONE  = 1;
    localparam logic [AMSB+1:0] LVL_FULL = (AMSB + 2)'(DEPTH);
    localparam logic [AMSB:0]   PTR_ONE  = 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH} state_t;

    state_t        state;
    logic [DMSB:0] mem [DEPTH];
    logic [AMSB:0] wptr;
    logic [AMSB:0] rptr;
    logic [1:0]    ed;
    logic          wr_ok;
    logic          pop;

    // Valid/ready: a byte is accepted on any edge where wr is high, the FIFO is
    // not full and clear is low; a byte is handed to uart_tx by toggling tx_push
    // while tx_wdata is already stable.
    assign wfull = (level == LVL_FULL);
    assign busy  = (state != IDLE);
    assign wr_ok = wr && !wfull && !clear;
    assign pop   = (state == IDLE) && setn && (level != '0) && (ed == 2'b11) && !clear;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            // A write while full is dropped even when a pop frees a slot this cycle.
            if (wr && wfull) begin
                overflow <= 1'b1;
            end
            case ({wr_ok, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            ed       <= 2'b00;
            tx_push  <= 1'b0;
            tx_wdata <= '0;
        end else begin
            ed <= {ed[0], tx_empty};
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_wdata <= mem[rptr];
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tx_push <= ~tx_push;
                    state   <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    // uart_tx has taken the byte once its empty flag drops.
                    if (!ed[1]) begin
                        state <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (ed == 2'b01) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed writes, a behavioural uart_tx model and a
// scoreboard that checks every launched byte against the write order.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       setn = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       clear = 1'b0;
    logic       tx_empty = 1'b1;
    logic       wfull;
    logic [4:0] level;
    logic       overflow;
    logic       busy;
    logic       tx_push;
    logic [7:0] tx_wdata;

    int         n_checks = 0;
    int         n_fail = 0;
    int         toggle_cnt = 0;
    int         hi_cnt = 0;
    logic [7:0] exp_q[$];

    uart_tx_fifo #(.DMSB(7), .AMSB(3)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .setn     (setn),
        .wr       (wr),
        .wdata    (wdata),
        .clear    (clear),
        .wfull    (wfull),
        .level    (level),
        .overflow (overflow),
        .busy     (busy),
        .tx_push  (tx_push),
        .tx_wdata (tx_wdata),
        .tx_empty (tx_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b, input bit accept);
        if (accept) exp_q.push_back(b);
        wr    = 1'b1;
        wdata = b;
        tick();
        wr = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i = 0;
        while ((busy || level != 5'd0 || !tx_empty) && i < 5000) begin
            tick();
            i++;
        end
        check(name, 32'(i < 5000), 32'd1);
    endtask

    task automatic wait_not_busy(input string name);
        int i = 0;
        while (busy && i < 1000) begin
            tick();
            i++;
        end
        check(name, 32'(i < 1000), 32'd1);
    endtask

    // uart_tx model and scoreboard monitor, working on the falling edge.
    initial begin
        logic last_push = 1'b0;
        int   low_cd = 0;
        int   high_cd = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                last_push = 1'b0;
                low_cd    = 0;
                high_cd   = 0;
                hi_cnt    = 0;
                tx_empty  = 1'b1;
            end else begin
                hi_cnt = tx_empty ? hi_cnt + 1 : 0;
                if (tx_push !== last_push) begin
                    last_push = tx_push;
                    toggle_cnt++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_push: got byte %0h, expected no launch", tx_wdata);
                    end else begin
                        check("push_data", 32'(tx_wdata), 32'(exp_q.pop_front()));
                    end
                    check("push_spacing", 32'(hi_cnt >= 4), 32'd1);
                    low_cd = 3;
                end
                if (low_cd > 0) begin
                    low_cd--;
                    if (low_cd == 0) begin
                        tx_empty = 1'b0;
                        high_cd  = 100;
                    end
                end else if (high_cd > 0) begin
                    high_cd--;
                    if (high_cd == 0) tx_empty = 1'b1;
                end
            end
        end
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int tc0;
        int written;
        int burst;
        int guard;

        // Reset values
        repeat (3) tick();
        check("rst_tx_push", 32'(tx_push), 32'd0);
        check("rst_tx_wdata", 32'(tx_wdata), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_wfull", 32'(wfull), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        repeat (3) tick();
        setn = 1'b1;

        // 1: single byte latency
        write_byte(8'h41, 1'b1);
        check("t1_level_after_write", 32'(level), 32'd1);
        check("t1_busy_after_write", 32'(busy), 32'd0);
        tick();
        check("t1_tx_wdata", 32'(tx_wdata), 32'h41);
        check("t1_level_after_pop", 32'(level), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_push_before", 32'(tx_push), 32'd0);
        tick();
        check("t1_push_after", 32'(tx_push), 32'd1);
        wait_idle("t1_idle_timeout");
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // 2: "ABC" back-to-back
        tc0 = toggle_cnt;
        write_byte(8'h41, 1'b1);
        write_byte(8'h42, 1'b1);
        write_byte(8'h43, 1'b1);
        wait_idle("t2_idle_timeout");
        check("t2_toggles", 32'(toggle_cnt - tc0), 32'd3);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // 3: fill with setn low, overflow, then drain
        setn = 1'b0;
        tc0 = toggle_cnt;
        for (int i = 0; i < 16; i++) write_byte(8'(8'h60 + i), 1'b1);
        check("t3_wfull", 32'(wfull), 32'd1);
        check("t3_level_full", 32'(level), 32'd16);
        check("t3_no_overflow_yet", 32'(overflow), 32'd0);
        write_byte(8'h7F, 1'b0);
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_level_held", 32'(level), 32'd16);
        check("t3_no_launch", 32'(toggle_cnt - tc0), 32'd0);
        setn = 1'b1;
        wait_idle("t3_idle_timeout");
        check("t3_toggles", 32'(toggle_cnt - tc0), 32'd16);
        check("t3_wfull_after", 32'(wfull), 32'd0);
        check("t3_overflow_sticky", 32'(overflow), 32'd1);

        // 4: write while full coinciding with a pop
        pulse_clear();
        check("t4_clear_overflow", 32'(overflow), 32'd0);
        setn = 1'b0;
        for (int i = 0; i < 16; i++) write_byte(8'(8'h80 + i), 1'b1);
        check("t4_wfull", 32'(wfull), 32'd1);
        setn  = 1'b1;
        wr    = 1'b1;
        wdata = 8'hEE;
        tick();
        wr   = 1'b0;
        setn = 1'b0;
        check("t4_level_15", 32'(level), 32'd15);
        check("t4_overflow", 32'(overflow), 32'd1);
        check("t4_busy", 32'(busy), 32'd1);
        wait_not_busy("t4_busy_timeout");
        check("t4_level_held", 32'(level), 32'd15);
        pulse_clear();
        exp_q.delete();
        check("t4_clear_level", 32'(level), 32'd0);
        check("t4_clear_overflow2", 32'(overflow), 32'd0);
        check("t4_clear_wfull", 32'(wfull), 32'd0);
        setn = 1'b1;
        repeat (4) tick();

        // 5: 40 random bytes in bursts, wrapping the pointers
        tc0 = toggle_cnt;
        written = 0;
        while (written < 40) begin
            burst = $urandom_range(1, 6);
            for (int j = 0; j < burst && written < 40; j++) begin
                guard = 0;
                while ((written - (toggle_cnt - tc0)) >= 16 && guard < 2000) begin
                    tick();
                    guard++;
                end
                if (guard >= 2000) check("t5_flow_timeout", 32'd0, 32'd1);
                write_byte(8'($urandom_range(0, 255)), 1'b1);
                written++;
            end
            repeat ($urandom_range(0, 30)) tick();
        end
        wait_idle("t5_idle_timeout");
        check("t5_toggles", 32'(toggle_cnt - tc0), 32'd40);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // 6: clear during WAIT_HIGH with 5 bytes queued
        tc0 = toggle_cnt;
        for (int i = 0; i < 6; i++) write_byte(8'(8'hA0 + i), 1'b1);
        guard = 0;
        while (tx_empty && guard < 100) begin
            tick();
            guard++;
        end
        check("t6_empty_drop", 32'(guard < 100), 32'd1);
        repeat (5) tick();
        check("t6_level_5", 32'(level), 32'd5);
        check("t6_busy_before", 32'(busy), 32'd1);
        pulse_clear();
        exp_q.delete();
        check("t6_level_cleared", 32'(level), 32'd0);
        check("t6_inflight_busy", 32'(busy), 32'd1);
        wait_not_busy("t6_busy_timeout");
        repeat (10) tick();
        check("t6_toggles", 32'(toggle_cnt - tc0), 32'd1);
        check("t6_level_final", 32'(level), 32'd0);
        check("t6_busy_final", 32'(busy), 32'd0);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
